vx_tex_unit_mc: RTL and testbench

//  Multi-client front end for the texture sampling pipeline. Accepts texture requests from NUM_REQS

---
 rtl/vx_tex_mc_pkg.sv | 21 ++
 rtl/vx_tex_mc_arb.sv | 37 +++
 rtl/vx_tex_unit_mc.sv | 111 +++++++++++
 tb/tb_vx_tex_unit_mc.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vx_tex_mc_pkg.sv
// vx_tex_mc_pkg: shared sizing helper and default request/response layouts for the multi-client texture front end
package vx_tex_mc_pkg;
  localparam int TEX_NUM_LANES = 4;
  localparam int TEX_TAG_WIDTH = 8;
  localparam int TEX_LOD_BITS = 4;
  localparam int TEX_STAGE_BITS = 1;
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic [TEX_NUM_LANES-1:0] mask;
    logic [2*TEX_NUM_LANES-1:0][31:0] coords;
    logic [TEX_NUM_LANES-1:0][TEX_LOD_BITS-1:0] lod;
    logic [TEX_STAGE_BITS-1:0] stage;
    logic [TEX_TAG_WIDTH-1:0] tag;
  } tex_mc_req_t;
  typedef struct packed {
    logic [TEX_NUM_LANES-1:0][31:0] texels;
    logic [TEX_TAG_WIDTH-1:0] tag;
  } tex_mc_rsp_t;
endpackage

// File: rtl/vx_tex_mc_arb.sv
// vx_tex_mc_arb: round-robin arbiter with grant enable, one-hot grant, grant index and rotating pointer
module vx_tex_mc_arb
  import vx_tex_mc_pkg::*;
#(
  parameter int N = 4,
  parameter int SB = sel_bits(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  valid,
  output logic [N-1:0]  grant,
  output logic [SB-1:0] grant_idx,
  output logic          grant_valid
);
  logic [SB-1:0] ptr;
  int best, d;
  // pick the valid requester with the smallest wrapped distance from the pointer
  always_comb begin
    best = N;
    d = 0;
    grant_idx = '0;
    for (int j = 0; j < N; j++) begin
      d = (j >= int'(ptr)) ? j - int'(ptr) : j + N - int'(ptr);
      if (valid[j] && d < best) begin
        best = d;
        grant_idx = SB'(j);
      end
    end
    grant_valid = en && (best < N);
    grant = '0;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (grant_valid) ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/vx_tex_unit_mc.sv
// vx_tex_unit_mc: multi-client texture front end (RR request mux, credit limit, response demux).
// Optional perf counters enabled by defining TEX_MC_PERF_EN.
module vx_tex_unit_mc
  import vx_tex_mc_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int NUM_LANES = TEX_NUM_LANES,
  parameter int TAG_WIDTH = TEX_TAG_WIDTH,
  parameter int LOD_BITS = TEX_LOD_BITS,
  parameter int STAGE_BITS = TEX_STAGE_BITS,
  parameter int MAX_PENDING = 8
`ifdef TEX_MC_PERF_EN
  , parameter int PERF_CTR_BITS = 32
`endif
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_REQS-1:0]                     req_valid,
  input  logic [NUM_REQS*NUM_LANES-1:0]           req_mask,
  input  logic [NUM_REQS*2*NUM_LANES*32-1:0]      req_coords,
  input  logic [NUM_REQS*NUM_LANES*LOD_BITS-1:0]  req_lod,
  input  logic [NUM_REQS*STAGE_BITS-1:0]          req_stage,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]           req_tag,
  output logic [NUM_REQS-1:0]                     req_ready,
  output logic [NUM_REQS-1:0]                     rsp_valid,
  output logic [NUM_REQS*NUM_LANES*32-1:0]        rsp_texels,
  output logic [NUM_REQS*TAG_WIDTH-1:0]           rsp_tag,
  input  logic [NUM_REQS-1:0]                     rsp_ready,
  output logic                                    dn_req_valid,
  input  logic                                    dn_req_ready,
  output logic [NUM_LANES-1:0]                    dn_req_mask,
  output logic [2*NUM_LANES*32-1:0]               dn_req_coords,
  output logic [NUM_LANES*LOD_BITS-1:0]           dn_req_lod,
  output logic [STAGE_BITS-1:0]                   dn_req_stage,
  output logic [TAG_WIDTH+sel_bits(NUM_REQS)-1:0] dn_req_tag,
  input  logic                                    dn_rsp_valid,
  input  logic [NUM_LANES*32-1:0]                 dn_rsp_texels,
  input  logic [TAG_WIDTH+sel_bits(NUM_REQS)-1:0] dn_rsp_tag,
  output logic                                    dn_rsp_ready
`ifdef TEX_MC_PERF_EN
  , output logic [PERF_CTR_BITS-1:0]              perf_stall_cycles,
  output logic [PERF_CTR_BITS-1:0]                perf_credit_stalls
`endif
);
  localparam int SB = sel_bits(NUM_REQS);
  localparam int PW = $clog2(MAX_PENDING + 1);
  logic [PW-1:0] pending;
  logic [SB-1:0] gidx, src;
  logic grant_en, req_fire, rsp_fire, src_ok;
  assign grant_en = (~dn_req_valid | dn_req_ready) & (int'(pending) < MAX_PENDING);
  vx_tex_mc_arb #(.N(NUM_REQS)) u_arb (
    .clk(clk),
    .reset(reset),
    .en(grant_en),
    .valid(req_valid),
    .grant(req_ready),
    .grant_idx(gidx),
    .grant_valid(req_fire)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dn_req_valid <= 1'b0;
      dn_req_mask <= '0;
      dn_req_coords <= '0;
      dn_req_lod <= '0;
      dn_req_stage <= '0;
      dn_req_tag <= '0;
    end else if (req_fire) begin
      dn_req_valid <= 1'b1;
      dn_req_mask <= req_mask[gidx*NUM_LANES +: NUM_LANES];
      dn_req_coords <= req_coords[gidx*2*NUM_LANES*32 +: 2*NUM_LANES*32];
      dn_req_lod <= req_lod[gidx*NUM_LANES*LOD_BITS +: NUM_LANES*LOD_BITS];
      dn_req_stage <= req_stage[gidx*STAGE_BITS +: STAGE_BITS];
      dn_req_tag <= {gidx, req_tag[gidx*TAG_WIDTH +: TAG_WIDTH]};
    end else if (dn_req_ready) dn_req_valid <= 1'b0;
  // responses are routed strictly in order; a full client register stalls the whole stream
  assign src = dn_rsp_tag[TAG_WIDTH+SB-1 -: SB];
  assign src_ok = int'(src) < NUM_REQS;
  assign dn_rsp_ready = ~src_ok | ~rsp_valid[src] | rsp_ready[src];
  assign rsp_fire = dn_rsp_valid & dn_rsp_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) pending <= '0;
    else if (req_fire != rsp_fire) pending <= req_fire ? pending + 1'b1 : pending - 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rsp_valid <= '0;
      rsp_texels <= '0;
      rsp_tag <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++)
        if (rsp_fire && src_ok && int'(src) == i) begin
          rsp_valid[i] <= 1'b1;
          rsp_texels[i*NUM_LANES*32 +: NUM_LANES*32] <= dn_rsp_texels;
          rsp_tag[i*TAG_WIDTH +: TAG_WIDTH] <= dn_rsp_tag[TAG_WIDTH-1:0];
        end else if (rsp_ready[i]) rsp_valid[i] <= 1'b0;
    end
`ifdef TEX_MC_PERF_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_credit_stalls <= '0;
    end else begin
      if (|req_valid && ~|req_ready) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (|req_valid && int'(pending) == MAX_PENDING) perf_credit_stalls <= perf_credit_stalls + 1'b1;
    end
`endif
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) rsp_fire |-> pending != '0)
    else $error("downstream response with nothing pending");
  a_src_range: assert property (@(posedge clk) disable iff (reset) dn_rsp_valid |-> src_ok)
    else $error("downstream response for nonexistent client");
endmodule

// File: tb/tb_vx_tex_unit_mc.sv
// tb_vx_tex_unit_mc: directed checks of arbitration, credit limit, response routing and async reset
module tb_vx_tex_unit_mc;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] req_valid, req_ready, rsp_valid, rsp_ready, req_stage;
  logic [15:0] req_mask;
  logic [1023:0] req_coords;
  logic [63:0] req_lod;
  logic [31:0] req_tag, rsp_tag;
  logic [511:0] rsp_texels;
  logic dn_req_valid, dn_req_ready, dn_rsp_valid, dn_rsp_ready;
  logic [3:0] dn_req_mask;
  logic [255:0] dn_req_coords;
  logic [15:0] dn_req_lod;
  logic [0:0] dn_req_stage;
  logic [9:0] dn_req_tag, dn_rsp_tag;
  logic [127:0] dn_rsp_texels;
  int total = 0, bad = 0, acc;
  logic [9:0] exp_tag [5] = '{10'h05A, 10'h177, 10'h233, 10'h344, 10'h05A};
  logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  vx_tex_unit_mc dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_mask(req_mask), .req_coords(req_coords), .req_lod(req_lod),
    .req_stage(req_stage), .req_tag(req_tag), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_texels(rsp_texels), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
    .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready), .dn_req_mask(dn_req_mask),
    .dn_req_coords(dn_req_coords), .dn_req_lod(dn_req_lod), .dn_req_stage(dn_req_stage),
    .dn_req_tag(dn_req_tag), .dn_rsp_valid(dn_rsp_valid), .dn_rsp_texels(dn_rsp_texels),
    .dn_rsp_tag(dn_rsp_tag), .dn_rsp_ready(dn_rsp_ready)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    req_valid = '0;
    dn_rsp_valid = 1'b0;
    rsp_ready = '1;
    dn_req_ready = 1'b1;
    tick;
    reset = 1'b0;
  endtask
  initial begin
    req_valid = '0;
    req_mask = 16'h8421;
    req_lod = 64'hDDDD_CCCC_BBBB_AAAA;
    req_stage = 4'b1010;
    req_tag = 32'h4433_775A;
    for (int j = 0; j < 32; j++) req_coords[j*32 +: 32] = 32'hC000_0000 + 32'(j);
    rsp_ready = '1;
    dn_req_ready = 1'b1;
    dn_rsp_valid = 1'b0;
    dn_rsp_tag = '0;
    dn_rsp_texels = {32'h4, 32'h3, 32'h2, 32'h1};
    tick;
    tick;
    reset = 1'b0;
    chk("rst_dn_req_valid", dn_req_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_pending", dut.pending, 0);
    chk("rst_dn_rsp_ready", dn_rsp_ready, 1);
    req_valid = 4'b0001;
    #1 chk("t1_ready", req_ready, 4'b0001);
    tick;
    chk("t1_dn_valid", dn_req_valid, 1);
    chk("t1_dn_tag", dn_req_tag, 10'h05A);
    chk("t1_dn_mask", dn_req_mask, 4'h1);
    chk("t1_dn_lod", dn_req_lod, 16'hAAAA);
    chk("t1_dn_coords", dn_req_coords[63:0], 64'hC000_0001_C000_0000);
    chk("t1_dn_stage", dn_req_stage, 0);
    req_valid = 4'b0010;
    dn_req_ready = 1'b0;
    #1 chk("t1_stall_ready", req_ready, 0);
    tick;
    chk("t1_stall_hold_tag", dn_req_tag, 10'h05A);
    chk("t1_stall_hold_valid", dn_req_valid, 1);
    dn_req_ready = 1'b1;
    #1 chk("t1_resume_ready", req_ready, 4'b0010);
    tick;
    req_valid = '0;
    chk("t1_c1_tag", dn_req_tag, 10'h177);
    chk("t1_c1_stage", dn_req_stage, 1);
    tick;
    chk("t1_drain", dn_req_valid, 0);
    do_reset;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t2_grant", req_ready, exp_gnt[k]);
      tick;
      chk("t2_tag", dn_req_tag, exp_tag[k]);
    end
    do_reset;
    req_valid = 4'b0001;
    acc = 0;
    repeat (12) begin
      #1 acc += int'(req_ready[0]);
      tick;
    end
    chk("t3_accepts", 64'(acc), 8);
    chk("t3_blocked", req_ready, 0);
    chk("t3_pending_full", dut.pending, 8);
    dn_rsp_valid = 1'b1;
    dn_rsp_tag = 10'h0AB;
    #1 chk("t3_rsp_ready", dn_rsp_ready, 1);
    chk("t3_blocked_rsp_cycle", req_ready, 0);
    tick;
    dn_rsp_valid = 1'b0;
    acc = 0;
    repeat (5) begin
      #1 acc += int'(req_ready[0]);
      tick;
    end
    chk("t3_one_more", 64'(acc), 1);
    chk("t3_pending_refull", dut.pending, 8);
    do_reset;
    rsp_ready = 4'b1011;
    req_valid = 4'b0001;
    tick;
    tick;
    req_valid = '0;
    dn_rsp_valid = 1'b1;
    dn_rsp_tag = 10'h211;
    #1 chk("t4_rsp_ready0", dn_rsp_ready, 1);
    tick;
    chk("t4_rsp_valid", rsp_valid, 4'b0100);
    chk("t4_rsp_tag", rsp_tag[23:16], 8'h11);
    chk("t4_rsp_texels", rsp_texels[256 +: 64], 64'h0000_0002_0000_0001);
    dn_rsp_tag = 10'h222;
    #1 chk("t4_backpressure", dn_rsp_ready, 0);
    tick;
    chk("t4_hold_tag", rsp_tag[23:16], 8'h11);
    rsp_ready[2] = 1'b1;
    #1 chk("t4_release", dn_rsp_ready, 1);
    tick;
    dn_rsp_valid = 1'b0;
    chk("t4_second_tag", rsp_tag[23:16], 8'h22);
    chk("t4_second_valid", rsp_valid, 4'b0100);
    tick;
    chk("t4_drained", rsp_valid, 0);
    chk("t4_pending", dut.pending, 0);
    do_reset;
    req_valid = 4'b0001;
    tick;
    tick;
    tick;
    dn_rsp_valid = 1'b1;
    dn_rsp_tag = 10'h0EE;
    #1 chk("t5_pending_before", dut.pending, 3);
    chk("t5_req_fire", req_ready, 4'b0001);
    chk("t5_rsp_fire", dn_rsp_ready, 1);
    tick;
    req_valid = '0;
    dn_rsp_valid = 1'b0;
    chk("t5_pending_after", dut.pending, 3);
    do_reset;
    req_valid = 4'b1111;
    repeat (6) tick;
    req_valid = '0;
    dn_req_ready = 1'b0;
    rsp_ready = 4'b0111;
    dn_rsp_valid = 1'b1;
    dn_rsp_tag = 10'h3F0;
    tick;
    dn_rsp_valid = 1'b0;
    chk("t6_pending5", dut.pending, 5);
    chk("t6_rsp_held", rsp_valid, 4'b1000);
    chk("t6_dn_valid", dn_req_valid, 1);
    #2 reset = 1'b1;
    #1 chk("t6_rst_dn_valid", dn_req_valid, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    chk("t6_rst_pending", dut.pending, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    dn_req_ready = 1'b1;
    rsp_ready = '1;
    req_valid = 4'b1111;
    #1 chk("t6_ptr_zero", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    chk("t6_first_tag", dn_req_tag, 10'h05A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
